game_controller: RTL and testbench
==================================

GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 The module SHALL have parameter CLK_HZ, default 25000000, meaning clock cycles per game second.
REQ-002 The module SHALL have parameter ROUND_SECONDS, default 60, meaning round length in seconds (1..127).
REQ-003 The module SHALL have parameter TARGET_SCORE, default 10, meaning hits needed to win (1..255).
REQ-004 The module SHALL have parameter MAX_MISSES, default 5, meaning misses that end the round (1..7).
REQ-005 clk  input  1  the single clock for all logic; reset  input  1  asynchronous, active-high.
REQ-006 start  input  1  single-cycle pulse from the debounced start button.
REQ-007 hit  input  1  single-cycle pulse when the player whacks the active mole.
REQ-008 miss  input  1  single-cycle pulse when the player whacks an empty hole.
REQ-009 screen_sel  output  2  displayed screen: 00 title, 01 play, 10 win, 11 lose; it selects win_screen's RGB when 10.
REQ-010 score  output  8  hits this round; time_left  output  7  seconds remaining; misses  output  3  misses this round.
REQ-011 mole_pos  output  4  active hole index, 4x4 grid; mole_valid  output  1  high only in PLAY.

Function
REQ-012 The FSM SHALL have states IDLE, PLAY, WIN and LOSE, encoded to drive screen_sel as 00/01/10/11 directly from a register.
REQ-013 IDLE SHALL go to PLAY on the edge where start=1, loading score=0, misses=0, time_left=ROUND_SECONDS, sec_cnt=0 and mole_pos=lfsr[3:0].
REQ-014 In PLAY, sec_cnt SHALL count 0..CLK_HZ-1 and wrap; at the wrap edge, time_left SHALL decrement by 1.
REQ-015 In PLAY, each hit SHALL increment score, saturating at 255, and load mole_pos=lfsr[3:0] on the same edge.
REQ-016 PLAY SHALL go to WIN on the same edge where the accepted hit makes score equal TARGET_SCORE.
REQ-017 PLAY SHALL go to LOSE on the edge where time_left would reach 0; time_left SHALL then read 0.
REQ-018 When hit and miss arrive in the same cycle, both SHALL be counted.
REQ-019 When a win and a lose condition occur on the same edge, WIN SHALL take priority.
REQ-020 hit and miss SHALL be ignored outside PLAY, and start SHALL be ignored in PLAY.
REQ-021 In WIN or LOSE, score, misses and time_left SHALL hold their values; start SHALL return the FSM to IDLE.
REQ-022 The LFSR SHALL be 8 bits, seeded 8'hA5, use polynomial x^8+x^6+x^5+x^4+1, and step every cycle in every state.
REQ-023 All outputs SHALL be registered, with no combinational path from an input to an output.

Reset
REQ-024 Reset SHALL asynchronously force: state IDLE, screen_sel=00, score=0, misses=0, time_left=ROUND_SECONDS, sec_cnt=0, mole_pos=0, mole_valid=0, lfsr=8'hA5.
REQ-025 Reset asserted mid-round SHALL abandon the round, and no partial score SHALL survive.

Configuration
REQ-026 With GAME_CTRL_MISS_LIMIT_EN defined, misses SHALL increment and saturate at 7, and PLAY SHALL go to LOSE on the edge where misses reaches MAX_MISSES.
REQ-027 Without GAME_CTRL_MISS_LIMIT_EN, the miss input SHALL be ignored, misses SHALL be tied to 0, and only timeout SHALL cause LOSE.

Structure
REQ-028 A shared package game_pkg SHALL hold the state/screen_sel encodings, the LFSR seed and taps, and the score and time widths.
REQ-029 The one-second prescaler SHALL be a sub-module named sec_tick, giving a one-cycle tick and clearing synchronously on enter-PLAY.

Verification (CLK_HZ=4, ROUND_SECONDS=3, TARGET_SCORE=2, MAX_MISSES=2)
REQ-030 Reset, then start pulse -> screen_sel=01 next cycle, time_left=3, score=0, mole_valid=1.
REQ-031 Two hit pulses 3 cycles apart -> score 1 then 2; screen_sel=10 on the second hit's edge; mole_pos changes on each hit.
REQ-032 No input for 12 cycles after start -> time_left steps 3,2,1 every 4 cycles, then LOSE with time_left=0.
REQ-033 Final hit on the same edge as timeout -> screen_sel=10, proving WIN priority.
REQ-034 Macro defined: two miss pulses -> misses=2 and screen_sel=11; macro undefined: misses stays 0 and the state stays 01.
REQ-035 Reset asserted mid-PLAY with score=1 -> all outputs at reset values asynchronously; start pulse in WIN -> IDLE next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings for the whack-a-mole game controller: FSM states, LFSR, field widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package game_pkg;

  // State codes double as the screen_sel encoding driven straight from the state register.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    WIN  = 2'b10,
    LOSE = 2'b11
  } state_t;

  localparam int SCORE_W = 8;
  localparam int TIME_W  = 7;
  localparam int MISS_W  = 3;
  localparam int POS_W   = 4;

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1: feedback taps on bits 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/game_controller_sec_tick.sv
// One-second prescaler: counts 0..CLK_HZ-1 while enabled, flags the wrap cycle.
// Latency: o_tick is high in the cycle whose closing edge wraps the counter.
// Backpressure: none; i_clear restarts the second synchronously, i_en freezes it.
module sec_tick #(
  parameter int CLK_HZ = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = i_en && w_last;

  // Free-running divider, restarted whenever a round begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_controller.sv
// Whack-a-mole round controller: title/play/win/lose FSM, score, timer, mole placement.
// Latency: every output is a register; inputs take effect on the next clock edge.
// Backpressure: none; pulses are consumed the cycle they arrive. Define GAME_CTRL_MISS_LIMIT_EN to count misses.
module game_controller
  import game_pkg::*;
#(
  parameter int CLK_HZ        = 25000000,
  parameter int ROUND_SECONDS = 60,
  parameter int TARGET_SCORE  = 10,
  parameter int MAX_MISSES    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               hit,
  input  logic               miss,
  output logic [1:0]         screen_sel,
  output logic [SCORE_W-1:0] score,
  output logic [TIME_W-1:0]  time_left,
  output logic [MISS_W-1:0]  misses,
  output logic [POS_W-1:0]   mole_pos,
  output logic               mole_valid
);

  localparam logic [TIME_W-1:0]  ROUND_T = TIME_W'(ROUND_SECONDS);
  localparam logic [SCORE_W-1:0] TARGET  = SCORE_W'(TARGET_SCORE);

  state_t             r_state;
  logic [7:0]         r_lfsr;
  logic [SCORE_W-1:0] r_score;
  logic [TIME_W-1:0]  r_time;
  logic [POS_W-1:0]   r_mole_pos;
  logic               r_mole_valid;

  logic               w_in_play;
  logic               w_enter_play;
  logic               w_tick;
  logic [SCORE_W-1:0] w_score_inc;
  logic               w_win;
  logic               w_timeout;
  logic               w_miss_lose;

  assign w_in_play    = (r_state == PLAY);
  assign w_enter_play = (r_state == IDLE) && start;
  assign w_score_inc  = (r_score == '1) ? r_score : r_score + SCORE_W'(1);
  assign w_win        = hit && (w_score_inc == TARGET);
  assign w_timeout    = w_tick && (r_time == TIME_W'(1));

`ifdef GAME_CTRL_MISS_LIMIT_EN
  logic [MISS_W-1:0] r_misses;
  logic [MISS_W-1:0] w_miss_inc;

  assign w_miss_inc  = (r_misses == '1) ? r_misses : r_misses + MISS_W'(1);
  assign w_miss_lose = miss && (w_miss_inc == MISS_W'(MAX_MISSES));
  assign misses      = r_misses;

  // Miss counter: cleared on round start, saturating count during play, frozen otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_misses <= '0;
    end else if (w_enter_play) begin
      r_misses <= '0;
    end else if (w_in_play && miss) begin
      r_misses <= w_miss_inc;
    end
  end
`else
  // Miss input and limit have no effect in this build; tie them off visibly.
  logic w_unused;
  assign w_unused    = ^{miss, MISS_W'(MAX_MISSES)};
  assign w_miss_lose = 1'b0;
  assign misses      = '0;
`endif

  sec_tick #(
    .CLK_HZ (CLK_HZ)
  ) u_sec_tick (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_enter_play),
    .i_en    (w_in_play),
    .o_tick  (w_tick)
  );

  // Pseudo-random mole placement source, stepping every cycle regardless of state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  // Game FSM with its registered score, timer and mole outputs; a win beats a loss on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_score      <= '0;
      r_time       <= ROUND_T;
      r_mole_pos   <= '0;
      r_mole_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state      <= PLAY;
            r_score      <= '0;
            r_time       <= ROUND_T;
            r_mole_pos   <= r_lfsr[POS_W-1:0];
            r_mole_valid <= 1'b1;
          end
        end
        PLAY: begin
          if (hit) begin
            r_score    <= w_score_inc;
            r_mole_pos <= r_lfsr[POS_W-1:0];
          end
          if (w_tick) begin
            r_time <= r_time - TIME_W'(1);
          end
          if (w_win) begin
            r_state      <= WIN;
            r_mole_valid <= 1'b0;
          end else if (w_timeout || w_miss_lose) begin
            r_state      <= LOSE;
            r_mole_valid <= 1'b0;
          end
        end
        WIN, LOSE: begin
          if (start) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_mole_valid <= 1'b0;
        end
      endcase
    end
  end

  assign screen_sel = r_state;
  assign score      = r_score;
  assign time_left  = r_time;
  assign mole_pos   = r_mole_pos;
  assign mole_valid = r_mole_valid;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with CLK_HZ=4, ROUND_SECONDS=3, TARGET_SCORE=2, MAX_MISSES=2.
// Inputs change and outputs are sampled 1ns after each rising edge.
// Expected values are hand-derived, including the LFSR sequence A5,4A,95,2A,54 after reset.
module tb_game_controller;

  logic       clk;
  logic       reset;
  logic       start;
  logic       hit;
  logic       miss;
  logic [1:0] screen_sel;
  logic [7:0] score;
  logic [6:0] time_left;
  logic [2:0] misses;
  logic [3:0] mole_pos;
  logic       mole_valid;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef GAME_CTRL_MISS_LIMIT_EN
  localparam bit MISS_EN = 1'b1;
`else
  localparam bit MISS_EN = 1'b0;
`endif

  game_controller #(
    .CLK_HZ        (4),
    .ROUND_SECONDS (3),
    .TARGET_SCORE  (2),
    .MAX_MISSES    (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .hit        (hit),
    .miss       (miss),
    .screen_sel (screen_sel),
    .score      (score),
    .time_left  (time_left),
    .misses     (misses),
    .mole_pos   (mole_pos),
    .mole_valid (mole_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    step();
    hit = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    hit   = 1'b0;
    miss  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_screen", screen_sel, 2'b00);
    chk("rst_score", score, 8'd0);
    chk("rst_time", time_left, 7'd3);
    chk("rst_misses", misses, 3'd0);
    chk("rst_pos", mole_pos, 4'd0);
    chk("rst_valid", mole_valid, 1'b0);

    // Start: LFSR still at seed A5 on this edge
    pulse_start();
    chk("start_screen", screen_sel, 2'b01);
    chk("start_time", time_left, 7'd3);
    chk("start_score", score, 8'd0);
    chk("start_valid", mole_valid, 1'b1);
    chk("start_pos", mole_pos, 4'h5);

    // First hit samples LFSR=4A
    pulse_hit();
    chk("hit1_score", score, 8'd1);
    chk("hit1_pos", mole_pos, 4'hA);
    chk("hit1_screen", screen_sel, 2'b01);
    step();
    step();
    // Second hit three cycles later samples LFSR=54, also the first second-wrap
    pulse_hit();
    chk("hit2_score", score, 8'd2);
    chk("hit2_pos", mole_pos, 4'h4);
    chk("hit2_screen", screen_sel, 2'b10);
    chk("hit2_valid", mole_valid, 1'b0);
    chk("hit2_time", time_left, 7'd2);
    repeat (3) step();
    chk("win_hold_time", time_left, 7'd2);
    chk("win_hold_score", score, 8'd2);
    pulse_hit();
    chk("win_ignore_hit", score, 8'd2);
    pulse_start();
    chk("win_to_idle", screen_sel, 2'b00);

    // Timeout round, with an ignored start pulse mid-round
    pulse_start();
    chk("to_start_time", time_left, 7'd3);
    for (int k = 1; k <= 12; k++) begin
      logic [6:0] exp_t;
      if (k == 5) start = 1'b1;
      step();
      start = 1'b0;
      exp_t = (k < 4) ? 7'd3 : (k < 8) ? 7'd2 : (k < 12) ? 7'd1 : 7'd0;
      chk($sformatf("to_time_k%0d", k), time_left, exp_t);
      if (k == 11) chk("to_screen_k11", screen_sel, 2'b01);
    end
    chk("to_screen_lose", screen_sel, 2'b11);
    chk("to_valid_lose", mole_valid, 1'b0);
    pulse_hit();
    chk("lose_ignore_hit", score, 8'd0);
    chk("lose_hold_screen", screen_sel, 2'b11);
    pulse_start();
    chk("lose_to_idle", screen_sel, 2'b00);

    // Final hit on the timeout edge: WIN wins
    pulse_start();
    pulse_hit();
    for (int k = 2; k <= 11; k++) step();
    chk("prio_pre_screen", screen_sel, 2'b01);
    pulse_hit();
    chk("prio_screen", screen_sel, 2'b10);
    chk("prio_score", score, 8'd2);

    // Misses: simultaneous hit+miss, then a second miss
    pulse_start();
    pulse_start();
    hit  = 1'b1;
    miss = 1'b1;
    step();
    hit  = 1'b0;
    miss = 1'b0;
    chk("hm_score", score, 8'd1);
    chk("hm_misses", misses, MISS_EN ? 3'd1 : 3'd0);
    chk("hm_screen", screen_sel, 2'b01);
    miss = 1'b1;
    step();
    miss = 1'b0;
    chk("miss2_misses", misses, MISS_EN ? 3'd2 : 3'd0);
    chk("miss2_screen", screen_sel, MISS_EN ? 2'b11 : 2'b01);

    // Asynchronous reset mid-round with score=1
    reset = 1'b1;
    step();
    reset = 1'b0;
    pulse_start();
    pulse_hit();
    chk("ar_pre_score", score, 8'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ar_screen", screen_sel, 2'b00);
    chk("ar_score", score, 8'd0);
    chk("ar_time", time_left, 7'd3);
    chk("ar_misses", misses, 3'd0);
    chk("ar_pos", mole_pos, 4'd0);
    chk("ar_valid", mole_valid, 1'b0);
    step();
    reset = 1'b0;
    pulse_hit();
    chk("idle_ignore_hit", score, 8'd0);
    chk("idle_stay", screen_sel, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
